// File: rtl/barrel_pkg.sv
// barrel_pkg: op codes, per-stage tag record and err decode shared by the barrel shifter pipeline
package barrel_pkg;
  localparam logic [2:0] OP_LSL  = 3'd0;
  localparam logic [2:0] OP_LSR  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  // width-independent part of a stage record; data and remaining amount ride alongside it
  typedef struct packed {
    logic [2:0] op;
    logic       carry;
    logic       valid;
  } tag_t;
  function automatic logic is_err(input logic [2:0] op);
    return op > OP_PASS;
  endfunction
endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one registered pipeline stage applying a conditional shift/rotate by 2**K
module shifter_stage
  import barrel_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 3,
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  prev_data,
  input  logic [SW-1:0] prev_amt,
  input  tag_t          prev_tag,
  output logic [W-1:0]  data,
  output logic [SW-1:0] amt,
  output tag_t          tag
);
  localparam int N = 1 << K;
  logic [W-1:0] shifted;
  logic out_bit;
  logic hit;
  // the last bit rotated out lands on the same source bit a shift would discard
  always_comb begin
    shifted = prev_tag.op == OP_LSL ? prev_data << N
            : prev_tag.op == OP_LSR ? prev_data >> N
            : prev_tag.op == OP_ASR ? W'($signed(prev_data) >>> N)
            : prev_tag.op == OP_ROL ? {prev_data[W-N-1:0], prev_data[W-1:W-N]}
            : {prev_data[N-1:0], prev_data[W-1:N]};
    out_bit = (prev_tag.op == OP_LSL || prev_tag.op == OP_ROL) ? prev_data[W-N] : prev_data[N-1];
  end
  assign hit = prev_amt[K] && prev_tag.op <= OP_ROR;
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      amt  <= '0;
      tag  <= '0;
    end else if (en) begin
      data <= hit ? shifted : prev_data;
      amt  <= prev_amt;
      tag  <= '{op: prev_tag.op, carry: hit ? out_bit : prev_tag.carry, valid: prev_tag.valid};
    end
  end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: SW-stage pipelined barrel shifter with valid/ready handshakes
// and carry/zero/err flags; the whole pipe stalls together on output backpressure.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  datain,
  input  logic [2:0]    op,
  input  logic [SW-1:0] s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  dataout,
  output logic          carry,
  output logic          zero,
  output logic          err
);
  logic [W-1:0]  data [SW+1];
  logic [SW-1:0] amt  [SW+1];
  tag_t          tag  [SW+1];
  logic          advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign data[0]  = datain;
  assign amt[0]   = s;
  assign tag[0]   = '{op: op, carry: 1'b0, valid: in_valid};
  for (genvar k = 0; k < SW; k++) begin : g_stage
    shifter_stage #(.W(W), .SW(SW), .K(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .prev_data (data[k]),
      .prev_amt  (amt[k]),
      .prev_tag  (tag[k]),
      .data      (data[k+1]),
      .amt       (amt[k+1]),
      .tag       (tag[k+1])
    );
  end
  // zero and err are gated so an idle or freshly reset pipe shows all-zero flags
  assign dataout   = data[SW];
  assign out_valid = tag[SW].valid;
  assign carry     = tag[SW].carry;
  assign zero      = out_valid && dataout == '0;
  assign err       = out_valid && is_err(tag[SW].op);
endmodule
